rxm_bar_slave: RTL and testbench

RXM_BAR_SLAVE -- requirements
Module: rxm_bar_slave

---
 rtl/rxm_bar_pkg.sv | 23 ++
 rtl/rxm_bar_ram.sv | 33 +++
 rtl/rxm_bar_slave.sv | 147 ++++++++++++++
 tb/tb_rxm_bar_slave.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rxm_bar_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rxm_bar_pkg
// Purpose : Shared constants for the Rxm BAR slave (FSM encoding, lane
//           width, read latency).
// Rev     : 1.0  initial release
// ============================================================================
package rxm_bar_pkg;

  // Number of byte lanes on the 64-bit Rxm data path
  localparam int RXM_BE_W = 8;

  // Cycles from the read-accepting edge to the first valid data beat
  localparam int RD_LATENCY = 2;

  // Slave FSM encoding; both read states share bit 1 so waitrequest is cheap
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WR_BURST = 2'd1;
  localparam logic [1:0] ST_RD_LAT   = 2'd2;
  localparam logic [1:0] ST_RD_BURST = 2'd3;

endpackage : rxm_bar_pkg
`default_nettype wire

// File: rtl/rxm_bar_ram.sv
`default_nettype none
// ============================================================================
// Module  : rxm_bar_ram
// Purpose : Single-port synchronous RAM, per-byte write enables, registered
//           read data (1-cycle latency, returns old data on a write).
// Rev     : 1.0  initial release
// ============================================================================
module rxm_bar_ram
  import rxm_bar_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                          clk,
  input  logic [$clog2(DEPTH)-1:0]      addr,
  input  logic [RXM_BE_W-1:0]           be,
  input  logic [RXM_BE_W*8-1:0]         wdata,
  output logic [RXM_BE_W*8-1:0]         rdata
);

  logic [RXM_BE_W*8-1:0] r_mem [DEPTH];

  // Byte-lane writes plus an unconditional registered read of the same word
  always_ff @(posedge clk) begin
    for (int b = 0; b < RXM_BE_W; b++) begin
      if (be[b]) begin
        r_mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata <= r_mem[addr];
  end

endmodule : rxm_bar_ram
`default_nettype wire

// File: rtl/rxm_bar_slave.sv
`default_nettype none
// ============================================================================
// Module  : rxm_bar_slave
// Purpose : Avalon-MM Rxm burst slave backed by an on-chip RAM. Handles
//           write bursts, fixed-latency read bursts and counts protocol
//           errors (zero burst count, read+write collisions, read during
//           a write burst) in a saturating counter.
// Rev     : 1.0  initial release
// ============================================================================
module rxm_bar_slave
  import rxm_bar_pkg::*;
#(
  parameter int AVALON_ADDR_WIDTH = 32,
  parameter int CB_RXM_DATA_WIDTH = 64,   // only 64 is supported
  parameter int MEM_DEPTH         = 256   // words, power of two
) (
  input  logic                          Clk_i,
  input  logic                          Rst_i,
  input  logic                          RxmWrite_0_o,
  input  logic                          RxmRead_0_o,
  input  logic [AVALON_ADDR_WIDTH-1:0]  RxmAddress_0_o,
  input  logic [CB_RXM_DATA_WIDTH-1:0]  RxmWriteData_0_o,
  input  logic [RXM_BE_W-1:0]           RxmByteEnable_0_o,
  input  logic [6:0]                    RxmBurstCount_0_o,
  output logic                          RxmWaitRequest_0_i,
  output logic [CB_RXM_DATA_WIDTH-1:0]  RxmReadData_0_i,
  output logic                          RxmReadDataValid_0_i,
  output logic [7:0]                    ErrCount_o
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx;     // next word to write / read
  logic [6:0]        r_left;    // beats still to write / issue
  logic              r_valid;
  logic [7:0]        r_err;

  logic [IDX_W-1:0]  w_addr_idx;
  logic              w_bc_zero;
  logic [6:0]        w_bc_eff;
  logic              w_idle;
  logic              w_wr_beat;
  logic [IDX_W-1:0]  w_ram_addr;
  logic [RXM_BE_W-1:0] w_ram_be;
  logic [63:0]       w_ram_rdata;
  logic [1:0]        w_err_inc;
  logic [8:0]        w_err_sum;
  logic              w_addr_unused;

  // Byte-offset and high address bits are don't-care; fold them away
  assign w_addr_unused = ^RxmAddress_0_o;

  // Request decode, RAM port steering and error-increment calculation
  always_comb begin
    w_addr_idx = RxmAddress_0_o[IDX_W+2:3];
    w_bc_zero  = (RxmBurstCount_0_o == 7'd0);
    w_bc_eff   = w_bc_zero ? 7'd1 : RxmBurstCount_0_o;
    w_idle     = (r_state == ST_IDLE);
    // Reset must block any RAM write, including one mid-burst
    w_wr_beat  = (w_idle || (r_state == ST_WR_BURST)) && RxmWrite_0_o && !Rst_i;
    // Beat 0 uses the bus address; later beats use the latched index
    w_ram_addr = w_idle ? w_addr_idx : r_idx;
    w_ram_be   = w_wr_beat ? RxmByteEnable_0_o : '0;

    w_err_inc = 2'd0;
    if (w_idle) begin
      // Zero count and read+write collision can both hit in one cycle
      w_err_inc = {1'b0, (RxmWrite_0_o || RxmRead_0_o) && w_bc_zero}
                + {1'b0, RxmWrite_0_o && RxmRead_0_o};
    end else if (r_state == ST_WR_BURST) begin
      w_err_inc = {1'b0, RxmRead_0_o};
    end
    w_err_sum = {1'b0, r_err} + {7'd0, w_err_inc};
  end

  // Burst FSM, address/beat counters, read-valid pipeline and error counter
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
      r_err   <= 8'd0;
    end else begin
      r_err   <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (RxmWrite_0_o) begin
            // Beat 0 is written this cycle; a simultaneous read is dropped
            r_idx  <= w_addr_idx + 1'b1;
            r_left <= w_bc_eff - 7'd1;
            if (w_bc_eff > 7'd1) begin
              r_state <= ST_WR_BURST;
            end
          end else if (RxmRead_0_o) begin
            r_idx   <= w_addr_idx;
            r_left  <= w_bc_eff;
            r_state <= ST_RD_LAT;
          end
        end
        ST_WR_BURST: begin
          if (RxmWrite_0_o) begin
            r_idx  <= r_idx + 1'b1;
            r_left <= r_left - 7'd1;
            if (r_left == 7'd1) begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_RD_LAT: begin
          r_state <= ST_RD_BURST;
        end
        ST_RD_BURST: begin
          // Issue one RAM read per cycle; the extra cycle after the last
          // issue is spent presenting the final beat
          if (r_left != 7'd0) begin
            r_idx   <= r_idx + 1'b1;
            r_left  <= r_left - 7'd1;
            r_valid <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  rxm_bar_ram #(
    .DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk   (Clk_i),
    .addr  (w_ram_addr),
    .be    (w_ram_be),
    .wdata (RxmWriteData_0_o),
    .rdata (w_ram_rdata)
  );

  assign RxmWaitRequest_0_i   = Rst_i || (r_state == ST_RD_LAT) || (r_state == ST_RD_BURST);
  assign RxmReadDataValid_0_i = r_valid;
  assign RxmReadData_0_i      = r_valid ? w_ram_rdata : '0;
  assign ErrCount_o           = r_err;

endmodule : rxm_bar_slave
`default_nettype wire

// File: tb/tb_rxm_bar_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_rxm_bar_slave
// Purpose : Directed self-checking bench for rxm_bar_slave.
// Rev     : 1.0  initial release
// ============================================================================
module tb_rxm_bar_slave;
  import rxm_bar_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr, rd;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic [6:0]  bc;
  logic        waitreq;
  logic [63:0] rdata;
  logic        rvalid;
  logic [7:0]  errcnt;

  int checks   = 0;
  int failures = 0;

  logic [63:0] wbuf [64];
  logic [63:0] rbuf [64];
  int rd_cnt, rd_first, rd_last, rd_wait_hi;
  int nv, guard;

  always #5 clk = ~clk;

  rxm_bar_slave #(
    .AVALON_ADDR_WIDTH (32),
    .CB_RXM_DATA_WIDTH (64),
    .MEM_DEPTH         (256)
  ) dut (
    .Clk_i                (clk),
    .Rst_i                (rst),
    .RxmWrite_0_o         (wr),
    .RxmRead_0_o          (rd),
    .RxmAddress_0_o       (addr),
    .RxmWriteData_0_o     (wdata),
    .RxmByteEnable_0_o    (be),
    .RxmBurstCount_0_o    (bc),
    .RxmWaitRequest_0_i   (waitreq),
    .RxmReadData_0_i      (rdata),
    .RxmReadDataValid_0_i (rvalid),
    .ErrCount_o           (errcnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input int n, input logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      wr = 1'b1; addr = a; wdata = wbuf[i]; be = b; bc = 7'(n);
      @(negedge clk);
    end
    wr = 1'b0; wdata = '0;
  endtask

  task automatic do_read(input logic [31:0] a, input int n);
    logic hi_run;
    rd_cnt = 0; rd_first = -1; rd_last = -1; rd_wait_hi = 0; hi_run = 1'b1;
    rd = 1'b1; addr = a; bc = 7'(n);
    @(negedge clk);
    rd = 1'b0;
    for (int c = 0; c < n + 6; c++) begin
      if (waitreq && hi_run) rd_wait_hi++;
      else hi_run = 1'b0;
      if (rvalid) begin
        if (rd_cnt < 64) rbuf[rd_cnt] = rdata;
        if (rd_first < 0) rd_first = c;
        rd_last = c;
        rd_cnt++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0; be = '0; bc = '0;
    repeat (3) @(negedge clk);
    check("rst_wait", {63'd0, waitreq}, 64'd1);
    check("rst_valid", {63'd0, rvalid}, 64'd0);
    check("rst_data", rdata, 64'd0);
    check("rst_err", {56'd0, errcnt}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_wait", {63'd0, waitreq}, 64'd0);

    // Single write / single read
    wbuf[0] = 64'h1122334455667788;
    do_write(32'h10, 1, 8'hFF);
    do_read(32'h10, 1);
    check("rd1_first", 64'(rd_first), 64'(RD_LATENCY));
    check("rd1_cnt", 64'(rd_cnt), 64'd1);
    check("rd1_data", rbuf[0], 64'h1122334455667788);
    check("rd1_wait_hi", 64'(rd_wait_hi), 64'd3);
    check("idle_data_zero", rdata, 64'd0);

    // Wrapping 4-beat burst at words 254,255,0,1
    for (int i = 0; i < 4; i++) wbuf[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
    do_write(32'h7F0, 4, 8'hFF);
    do_read(32'h7F0, 4);
    check("wrap_cnt", 64'(rd_cnt), 64'd4);
    check("wrap_first", 64'(rd_first), 64'd2);
    check("wrap_nogap", 64'(rd_last), 64'd5);
    for (int i = 0; i < 4; i++)
      check($sformatf("wrap_beat%0d", i), rbuf[i], 64'hC0DE_0000_0000_0000 + 64'(i));

    // Partial byte enables, then all-zero enables
    wbuf[0] = 64'hFFFFFFFFFFFFFFFF;
    do_write(32'h20, 1, 8'hFF);
    wbuf[0] = 64'hAAAAAAAABBBBBBBB;
    do_write(32'h20, 1, 8'h0F);
    do_read(32'h20, 1);
    check("be0f_data", rbuf[0], 64'hFFFFFFFFBBBBBBBB);
    wbuf[0] = 64'h0123012301230123;
    do_write(32'h20, 1, 8'h00);
    do_read(32'h20, 1);
    check("be00_data", rbuf[0], 64'hFFFFFFFFBBBBBBBB);

    // 64-beat read from word 0
    do_read(32'h0, 64);
    check("rd64_wait_hi", 64'(rd_wait_hi), 64'd66);
    check("rd64_cnt", 64'(rd_cnt), 64'd64);
    check("rd64_first", 64'(rd_first), 64'd2);
    check("rd64_nogap", 64'(rd_last), 64'd65);
    check("rd64_beat0", rbuf[0], 64'hC0DE_0000_0000_0002);
    check("rd64_beat1", rbuf[1], 64'hC0DE_0000_0000_0003);
    check("rd64_beat2", rbuf[2], 64'h1122334455667788);
    check("rd64_beat4", rbuf[4], 64'hFFFFFFFFBBBBBBBB);
    check("err_before", {56'd0, errcnt}, 64'd0);

    // Read+write collision with burst count 0
    wr = 1'b1; rd = 1'b1; bc = 7'd0; addr = 32'h40; wdata = 64'hCAFEF00D12345678; be = 8'hFF;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; wdata = '0;
    nv = 0;
    for (int c = 0; c < 5; c++) begin
      if (rvalid) nv++;
      @(negedge clk);
    end
    check("coll_no_rdata", 64'(nv), 64'd0);
    check("coll_err", {56'd0, errcnt}, 64'd2);
    do_read(32'h40, 1);
    check("coll_wdata", rbuf[0], 64'hCAFEF00D12345678);

    // Read asserted during a write burst
    wr = 1'b1; rd = 1'b0; bc = 7'd2; addr = 32'h50; wdata = 64'h0123456789ABCDEF; be = 8'hFF;
    @(negedge clk);
    check("wrb_wait_low", {63'd0, waitreq}, 64'd0);
    rd = 1'b1; addr = 32'h999; wdata = 64'hFEDCBA9876543210;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    @(negedge clk);
    check("wrb_err", {56'd0, errcnt}, 64'd3);
    do_read(32'h58, 1);
    check("wrb_beat1", rbuf[0], 64'hFEDCBA9876543210);

    // Saturation: each collision cycle adds two
    for (int i = 0; i < 127; i++) begin
      wr = 1'b1; rd = 1'b1; bc = 7'd0; addr = 32'h400; wdata = '0; be = 8'hFF;
      @(negedge clk);
    end
    wr = 1'b0; rd = 1'b0;
    check("err_sat", {56'd0, errcnt}, 64'd255);

    // Reset after the third beat of an 8-beat read
    rd = 1'b1; addr = 32'h0; bc = 7'd8;
    @(negedge clk);
    rd = 1'b0;
    nv = 0; guard = 0;
    while (nv < 3 && guard < 20) begin
      if (rvalid) nv++;
      if (nv < 3) begin
        @(negedge clk);
        guard++;
      end
    end
    check("rst_mid_beats", 64'(nv), 64'd3);
    check("rst_mid_beat3", rdata, 64'h1122334455667788);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_wait", {63'd0, waitreq}, 64'd1);
    check("rst_mid_valid", {63'd0, rvalid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_release_wait", {63'd0, waitreq}, 64'd0);
    check("rst_mid_err", {56'd0, errcnt}, 64'd0);
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      if (rvalid) nv++;
      @(negedge clk);
    end
    check("rst_mid_no_beats", 64'(nv), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rxm_bar_slave
`default_nettype wire
